shell_ballistics: RTL and testbench

Per-frame projectile engine for the tank game. It sits between the gamepad/aim state (power, angle, fire) and the pixel renderer. On a fire press it launches a shell from the tank muzzle and advances it once per frame under gravity. It detects ground impact by sampling the terrain height stream at the shell's column during active video, and reports the shell position for drawing.

---
 rtl/shell_ballistics.sv | 189 ++++++++++++++++++
 tb/tb_shell_ballistics.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/shell_ballistics.sv
// rtl/shell_ballistics.sv - per-frame projectile engine: launch, gravity flight, ground impact, explosion hold
module shell_ballistics #(
  parameter int START_X       = 40,
  parameter int START_Y       = 100,
  parameter int GRAVITY       = 2,
  parameter int IMPACT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [7:0] power,
  input  logic [7:0] angle,
  input  logic [9:0] x,
  input  logic       video_active,
  input  logic [7:0] height,
  output logic       busy,
  output logic       shell_visible,
  output logic [9:0] shell_x,
  output logic [9:0] shell_y,
  output logic       impact,
  output logic       exploding
);

  typedef enum logic [1:0] {IDLE, FLIGHT, IMPACT} state_t;

  localparam logic [13:0] PX0 = 14'(START_X * 16);
  localparam logic [15:0] PY0 = 16'(START_Y * 16);

  state_t             state_q, state_d;
  logic [13:0]        px_q, px_d;
  logic signed [15:0] py_q, py_d;
  logic [7:0]         vx_q, vx_d;
  logic signed [10:0] vy_q, vy_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         ground_h;
  logic               fire_q;
  logic               launch;
  logic               impact_d;
  logic               visible_d;

  logic [9:0]         pxi, pxi_d;
  logic signed [11:0] pyi, pyi_d;
  logic               y_on, y_low;
  logic [3:0]         sin_v, cos_v;
  logic [11:0]        prod_c, prod_s;
  logic signed [11:0] vy_sum;
  logic signed [10:0] vy_grav;
  logic               unused_bits;

  // Quarter-wave sine in 1/16 units, indexed 0..16 over 0..90 degrees
  function automatic logic [3:0] trig(input logic [4:0] k);
    case (k)
      5'd0:    trig = 4'd0;
      5'd1:    trig = 4'd1;
      5'd2:    trig = 4'd3;
      5'd3:    trig = 4'd4;
      5'd4:    trig = 4'd6;
      5'd5:    trig = 4'd7;
      5'd6:    trig = 4'd8;
      5'd7:    trig = 4'd10;
      5'd8:    trig = 4'd11;
      5'd9:    trig = 4'd12;
      5'd10:   trig = 4'd12;
      5'd11:   trig = 4'd13;
      5'd12:   trig = 4'd14;
      5'd13:   trig = 4'd14;
      default: trig = 4'd15;
    endcase
  endfunction

  assign pxi    = px_q[13:4];
  assign pyi    = py_q[15:4];
  assign pxi_d  = px_d[13:4];
  assign pyi_d  = py_d[15:4];
  assign y_on   = (pyi >= 12'sd0) && (pyi <= 12'sd479);
  assign y_low  = pyi > 12'sd479;
  assign launch = fire & ~fire_q;

  assign sin_v  = trig({1'b0, angle[7:4]});
  assign cos_v  = trig(5'd16 - {1'b0, angle[7:4]});
  assign prod_c = {4'b0, power} * {8'b0, cos_v};
  assign prod_s = {4'b0, power} * {8'b0, sin_v};

  // Gravity step with saturation at the top of the signed 11-bit range
  assign vy_sum  = {vy_q[10], vy_q} + 12'(GRAVITY);
  assign vy_grav = (vy_sum > 12'sd1023) ? 11'sd1023 : vy_sum[10:0];

  assign unused_bits = ^{angle[3:0], prod_c[3:0], prod_s[3:0]};

  // Edge detector; starts high so a button held through reset is not a launch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fire_q <= 1'b1;
    else        fire_q <= fire;
  end

  // Terrain height under the shell column, captured during active video
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ground_h <= 8'd255;
    else if (video_active && x == pxi)   ground_h <= height;
  end

  // Next-state, kinematics and output decode
  always_comb begin
    state_d  = state_q;
    px_d     = px_q;
    py_d     = py_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    cnt_d    = cnt_q;
    impact_d = 1'b0;
    case (state_q)
      IDLE: begin
        px_d = PX0;
        py_d = PY0;
        if (launch) begin
          vx_d    = prod_c[11:4];
          vy_d    = 11'sd0 - $signed({3'b000, prod_s[11:4]});
          state_d = FLIGHT;
        end
      end
      FLIGHT: begin
        if (frame_tick) begin
          if (y_on && (pyi > $signed({4'b0000, ground_h}))) begin
            state_d  = IMPACT;
            impact_d = 1'b1;
            cnt_d    = 8'(IMPACT_FRAMES);
          end else if (pxi >= 10'd640 || y_low) begin
            state_d = IDLE;
            px_d    = PX0;
            py_d    = PY0;
          end else begin
            px_d = px_q + {6'b0, vx_q};
            py_d = py_q + {{5{vy_q[10]}}, vy_q};
            vy_d = vy_grav;
          end
        end
      end
      IMPACT: begin
        if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_d = IDLE;
            px_d    = PX0;
            py_d    = PY0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    visible_d = (state_d != IDLE) && (pyi_d >= 12'sd0) && (pyi_d <= 12'sd479)
                && (pxi_d < 10'd640);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Shell kinematics and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q          <= PX0;
      py_q          <= PY0;
      vx_q          <= 8'd0;
      vy_q          <= 11'sd0;
      cnt_q         <= 8'd0;
      busy          <= 1'b0;
      shell_visible <= 1'b0;
      impact        <= 1'b0;
      exploding     <= 1'b0;
    end else begin
      px_q          <= px_d;
      py_q          <= py_d;
      vx_q          <= vx_d;
      vy_q          <= vy_d;
      cnt_q         <= cnt_d;
      busy          <= (state_d != IDLE);
      shell_visible <= visible_d;
      impact        <= impact_d;
      exploding     <= (state_d == IMPACT);
    end
  end

  assign shell_x = pxi;
  assign shell_y = pyi[9:0];

endmodule

// File: tb/tb_shell_ballistics.sv
// tb/tb_shell_ballistics.sv - directed vector bench for shell_ballistics
module tb_shell_ballistics;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       fire = 1'b0;
  logic [7:0] power = 8'd0;
  logic [7:0] angle = 8'd0;
  logic [9:0] x = 10'd0;
  logic       video_active = 1'b0;
  logic [7:0] height = 8'd255;
  logic       busy, shell_visible, impact, exploding;
  logic [9:0] shell_x, shell_y;

  int n_checks = 0;
  int n_err = 0;
  int impact_cnt = 0;

  shell_ballistics dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fire),
    .power(power), .angle(angle), .x(x), .video_active(video_active),
    .height(height), .busy(busy), .shell_visible(shell_visible),
    .shell_x(shell_x), .shell_y(shell_y), .impact(impact), .exploding(exploding)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (impact === 1'b1) impact_cnt++;

  typedef struct {
    logic [7:0] power;
    logic [7:0] angle;
    int x1, y1, x2, y2;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fire = 1'b0;
    frame_tick = 1'b0;
    video_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_launch(input logic [7:0] p, input logic [7:0] a);
    power = p;
    angle = a;
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
  endtask

  task automatic frame();
    video_active = 1'b1;
    x = (shell_x < 10'd640) ? shell_x : 10'd0;
    @(negedge clk);
    @(negedge clk);
    video_active = 1'b0;
    x = 10'd0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'd160, 8'h00, 49, 100, 58, 100};
    vecs[1] = '{8'd255, 8'hF0, 40,  85, 41,  70};
    vecs[2] = '{8'd0,   8'h00, 40, 100, 40, 100};
    vecs[3] = '{8'd200, 8'h80, 48,  91, 57,  83};
    vecs[4] = '{8'd100, 8'h40, 45,  97, 50,  95};
    vecs[5] = '{8'd255, 8'h3F, 53,  96, 67,  92};

    // Reset with fire held
    fire = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_visible", shell_visible, 0);
    check("rst_impact", impact, 0);
    check("rst_exploding", exploding, 0);
    check("rst_x", shell_x, 40);
    check("rst_y", shell_y, 100);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) frame();
    check("held_busy", busy, 0);
    check("held_x", shell_x, 40);
    check("held_y", shell_y, 100);
    fire = 1'b0;
    @(negedge clk);
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    check("repress_busy", busy, 1);

    // Launch vectors
    height = 8'd255;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      do_launch(vecs[v].power, vecs[v].angle);
      check($sformatf("v%0d_busy", v), busy, 1);
      frame();
      check($sformatf("v%0d_x1", v), shell_x, vecs[v].x1);
      check($sformatf("v%0d_y1", v), shell_y, vecs[v].y1);
      frame();
      check($sformatf("v%0d_x2", v), shell_x, vecs[v].x2);
      check($sformatf("v%0d_y2", v), shell_y, vecs[v].y2);
    end

    // Launch coinciding with frame_tick: no motion on that tick
    do_reset();
    power = 8'd160;
    angle = 8'h00;
    fire = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    frame_tick = 1'b0;
    check("coinc_busy", busy, 1);
    check("coinc_x", shell_x, 40);
    @(negedge clk);
    frame();
    check("coinc_x1", shell_x, 49);

    // Drop impact
    do_reset();
    height = 8'd110;
    impact_cnt = 0;
    do_launch(8'd0, 8'h00);
    for (int i = 0; i < 14; i++) frame();
    check("drop_y14", shell_y, 111);
    check("drop_no_impact", impact_cnt, 0);
    frame();
    check("drop_impact", impact, 1);
    check("drop_exploding", exploding, 1);
    check("drop_x", shell_x, 40);
    check("drop_y", shell_y, 111);
    check("drop_visible", shell_visible, 1);
    @(negedge clk);
    check("drop_impact_low", impact, 0);
    for (int i = 0; i < 29; i++) frame();
    check("drop_busy29", busy, 1);
    check("drop_expl29", exploding, 1);
    check("drop_y_frozen", shell_y, 111);
    frame();
    check("drop_busy30", busy, 0);
    check("drop_expl30", exploding, 0);
    check("drop_pulses", impact_cnt, 1);

    // Right-edge miss
    do_reset();
    height = 8'd255;
    impact_cnt = 0;
    do_launch(8'd255, 8'h00);
    for (int i = 0; i < 40; i++) frame();
    check("edge_x40", shell_x, 637);
    check("edge_y40", shell_y, 197);
    check("edge_vis40", shell_visible, 1);
    frame();
    check("edge_x41", shell_x, 652);
    check("edge_vis41", shell_visible, 0);
    check("edge_busy41", busy, 1);
    frame();
    check("edge_busy42", busy, 0);
    check("edge_x42", shell_x, 40);
    check("edge_pulses", impact_cnt, 0);

    // Ignored fire mid-flight, then asynchronous reset
    do_reset();
    do_launch(8'd200, 8'h80);
    frame();
    check("ign_x1", shell_x, 48);
    power = 8'd10;
    angle = 8'h00;
    fire = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    @(negedge clk);
    frame();
    check("ign_x2", shell_x, 57);
    check("ign_y2", shell_y, 83);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", busy, 0);
    check("async_x", shell_x, 40);
    check("async_y", shell_y, 100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
